// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: datapath widths, reset values,
// memory-op/size encodings, FSM states and byte-lane helper functions.
package mem_access_stage_pkg;

  localparam int DataSize    = 32;
  localparam int RegAddrSize = 5;

  localparam logic [DataSize-1:0]    DataBusReset = 32'h0000_0000;
  localparam logic [RegAddrSize-1:0] RegAddrReset = 5'd0;

  typedef enum logic [1:0] {
    MemOpNone  = 2'd0,
    MemOpLoad  = 2'd1,
    MemOpStore = 2'd2,
    MemOpRsvd  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    MemSizeByte = 2'd0,
    MemSizeHalf = 2'd1,
    MemSizeWord = 2'd2,
    MemSizeRsvd = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Byte enables for an access of the given size at byte offset off.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MemSizeByte: byte_enable = 4'b0001 << off;
      MemSizeHalf: byte_enable = 4'b0011 << off;
      default:     byte_enable = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so any enabled lane carries it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      MemSizeByte: store_lanes = {4{d[7:0]}};
      MemSizeHalf: store_lanes = {2{d[15:0]}};
      default:     store_lanes = d;
    endcase
  endfunction

  // Clears the address bits an access of this size may not use.
  // The reserved size behaves like a word access.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MemSizeByte: force_align = off;
      MemSizeHalf: force_align = {off[1], 1'b0};
      default:     force_align = 2'b00;
    endcase
  endfunction

  // True when the offset is illegal for the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MemSizeByte: misaligned = 1'b0;
      MemSizeHalf: misaligned = off[0];
      default:     misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it to the full datapath width. Purely combinational.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [DataSize-1:0] rdata,
  input  logic [1:0]          offset,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic [DataSize-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to size and signedness.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = DataBusReset;
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      MemSizeByte: begin
        if (is_unsigned) begin
          data = {24'h00_0000, byte_s};
        end else begin
          data = {{24{byte_s[7]}}, byte_s};
        end
      end
      MemSizeHalf: begin
        if (is_unsigned) begin
          data = {16'h0000, half_s};
        end else begin
          data = {{16{half_s[15]}}, half_s};
        end
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage. Passes ALU results through, or performs
// byte/half/word loads and stores over a req/ack data-memory port with a
// timeout, stalling upstream while an access is outstanding.
// Optional feature macro MEM_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses raise a bus error instead of being silently aligned.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DataSize,
  parameter int REG_AW  = RegAddrSize,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              validIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] storeDataIn,
  input  logic [1:0]        memOpIn,
  input  logic [1:0]        memSizeIn,
  input  logic              memUnsignedIn,
  input  logic              writeEnableIn,
  input  logic [REG_AW-1:0] writeBackAddrIn,
  output logic              stallOut,
  output logic              validOut,
  output logic              writeEnableOut,
  output logic [REG_AW-1:0] writeBackAddrOut,
  output logic [DATA_W-1:0] dataOut,
  output logic              busErrOut,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memBe,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdata
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_r;
  logic [CntW-1:0]   cnt_r;
  logic [DATA_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic              store_r;
  logic              we_r;
  logic [REG_AW-1:0] wbaddr_r;

  logic              valid_out_r;
  logic              we_out_r;
  logic [REG_AW-1:0] wb_out_r;
  logic [DATA_W-1:0] data_out_r;
  logic              bus_err_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [3:0]        mem_be_r;

  logic              is_load_s;
  logic              is_store_s;
  logic              is_mem_s;
  logic              trap_s;
  logic [DATA_W-1:0] eff_addr_s;
  logic [DATA_W-1:0] load_data_s;

  // Decode of the presented instruction and its effective (aligned) address.
  always_comb begin
    is_load_s  = validIn && (memOpIn == MemOpLoad);
    is_store_s = validIn && (memOpIn == MemOpStore);
    is_mem_s   = is_load_s || is_store_s;
    eff_addr_s = {dataIn[DATA_W-1:2], force_align(memSizeIn, dataIn[1:0])};
`ifdef MEM_MISALIGN_TRAP_EN
    trap_s     = misaligned(memSizeIn, dataIn[1:0]);
`else
    trap_s     = 1'b0;
`endif
  end

  // Upstream hold: a memory op waiting in IDLE, or any cycle of ACCESS.
  always_comb begin
    stallOut = ((state_r == StIdle) && is_mem_s) || (state_r == StAccess);
  end

  load_align u_load_align (
    .rdata       (memRdata),
    .offset      (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .data        (load_data_s)
  );

  // Stage FSM: accept in IDLE/DONE, run the memory handshake in ACCESS.
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      state_r     <= StIdle;
      cnt_r       <= '0;
      addr_r      <= DataBusReset;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      store_r     <= 1'b0;
      we_r        <= 1'b0;
      wbaddr_r    <= RegAddrReset;
      valid_out_r <= 1'b0;
      we_out_r    <= 1'b0;
      wb_out_r    <= RegAddrReset;
      data_out_r  <= DataBusReset;
      bus_err_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= DataBusReset;
      mem_wdata_r <= DataBusReset;
      mem_be_r    <= 4'b0000;
    end else begin
      bus_err_r <= 1'b0;
      case (state_r)
        StIdle, StDone: begin
          if (is_mem_s) begin
            addr_r      <= eff_addr_s;
            size_r      <= memSizeIn;
            unsigned_r  <= memUnsignedIn;
            store_r     <= is_store_s;
            we_r        <= writeEnableIn;
            wbaddr_r    <= writeBackAddrIn;
            we_out_r    <= 1'b0;
            cnt_r       <= '0;
            if (trap_s) begin
              // Illegal alignment: no bus traffic, report an error next cycle.
              valid_out_r <= 1'b1;
              bus_err_r   <= 1'b1;
              wb_out_r    <= writeBackAddrIn;
              data_out_r  <= eff_addr_s;
              state_r     <= StDone;
            end else begin
              valid_out_r <= 1'b0;
              mem_req_r   <= 1'b1;
              mem_we_r    <= is_store_s;
              mem_addr_r  <= {eff_addr_s[DATA_W-1:2], 2'b00};
              mem_be_r    <= byte_enable(memSizeIn, eff_addr_s[1:0]);
              mem_wdata_r <= store_lanes(memSizeIn, storeDataIn);
              state_r     <= StAccess;
            end
          end else if (validIn) begin
            valid_out_r <= 1'b1;
            we_out_r    <= writeEnableIn;
            wb_out_r    <= writeBackAddrIn;
            data_out_r  <= dataIn;
            state_r     <= StIdle;
          end else begin
            valid_out_r <= 1'b0;
            we_out_r    <= 1'b0;
            state_r     <= StIdle;
          end
        end
        StAccess: begin
          if (memAck) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            valid_out_r <= 1'b1;
            we_out_r    <= store_r ? 1'b0 : we_r;
            wb_out_r    <= wbaddr_r;
            data_out_r  <= store_r ? addr_r : load_data_s;
            cnt_r       <= '0;
            state_r     <= StDone;
          end else if (cnt_r == CntLast) begin
            // Memory never answered: abandon the request and flag an error.
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            valid_out_r <= 1'b1;
            we_out_r    <= 1'b0;
            wb_out_r    <= wbaddr_r;
            data_out_r  <= addr_r;
            bus_err_r   <= 1'b1;
            cnt_r       <= '0;
            state_r     <= StDone;
          end else begin
            cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= StIdle;
          mem_req_r   <= 1'b0;
          valid_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign validOut         = valid_out_r;
  assign writeEnableOut   = we_out_r;
  assign writeBackAddrOut = wb_out_r;
  assign dataOut          = data_out_r;
  assign busErrOut        = bus_err_r;
  assign memReq           = mem_req_r;
  assign memWe            = mem_we_r;
  assign memAddr          = mem_addr_r;
  assign memWdata         = mem_wdata_r;
  assign memBe            = mem_be_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        validIn;
  logic [31:0] dataIn;
  logic [31:0] storeDataIn;
  logic [1:0]  memOpIn;
  logic [1:0]  memSizeIn;
  logic        memUnsignedIn;
  logic        writeEnableIn;
  logic [4:0]  writeBackAddrIn;
  logic        stallOut;
  logic        validOut;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;
  logic [31:0] dataOut;
  logic        busErrOut;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memAck;
  logic [31:0] memRdata;

  int n_vec  = 0;
  int n_miss = 0;

  // Captured by run_mem
  int          stall_n, req_n, berr_n, lat;
  logic        unstable;
  logic [31:0] c_addr, c_wdata, c_data;
  logic [3:0]  c_be;
  logic        c_we, c_weo;
  logic [4:0]  c_wb;

  mem_access_stage dut (
    .clk(clk), .resetIn(resetIn), .validIn(validIn), .dataIn(dataIn),
    .storeDataIn(storeDataIn), .memOpIn(memOpIn), .memSizeIn(memSizeIn),
    .memUnsignedIn(memUnsignedIn), .writeEnableIn(writeEnableIn),
    .writeBackAddrIn(writeBackAddrIn), .stallOut(stallOut), .validOut(validOut),
    .writeEnableOut(writeEnableOut), .writeBackAddrOut(writeBackAddrOut),
    .dataOut(dataOut), .busErrOut(busErrOut), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe), .memAck(memAck),
    .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one memory op, acks ack_dly cycles after memReq should rise
  // (negative = never), and records what happened until validOut.
  task automatic run_mem(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_dly);
    stall_n = 0; req_n = 0; berr_n = 0; lat = -1; unstable = 1'b0;
    c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0; c_we = 1'b0;
    c_data = 32'h0; c_weo = 1'b0; c_wb = 5'd0;
    validIn = 1'b1; memOpIn = op; memSizeIn = size; memUnsignedIn = uns;
    dataIn = addr; storeDataIn = sdata; writeEnableIn = 1'b1;
    writeBackAddrIn = 5'd7; memRdata = rdata;
    for (int k = 0; k < 40; k++) begin
      memAck = (ack_dly >= 0) && (k == ack_dly + 1);
      @(negedge clk);
      if (stallOut) stall_n++;
      if (busErrOut) berr_n++;
      if (memReq) begin
        if (req_n > 0 && (memAddr !== c_addr || memBe !== c_be ||
                          memWdata !== c_wdata || memWe !== c_we)) unstable = 1'b1;
        req_n++;
        c_addr = memAddr; c_be = memBe; c_wdata = memWdata; c_we = memWe;
      end
      if (validOut) begin
        lat = k; c_data = dataOut; c_weo = writeEnableOut; c_wb = writeBackAddrOut;
        break;
      end
      @(posedge clk);
      #1;
      validIn = 1'b0;
    end
    memAck = 1'b0;
    validIn = 1'b0;
    if (lat < 0) chk("timeout_no_validOut", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    resetIn = 1'b0; validIn = 1'b0; dataIn = 32'h0; storeDataIn = 32'h0;
    memOpIn = 2'd0; memSizeIn = 2'd0; memUnsignedIn = 1'b0; writeEnableIn = 1'b0;
    writeBackAddrIn = 5'd0; memAck = 1'b0; memRdata = 32'h0;
    step(); step();
    @(negedge clk);
    chk("rst_stall", {31'd0, stallOut}, 32'd0);
    chk("rst_valid", {31'd0, validOut}, 32'd0);
    chk("rst_we", {31'd0, writeEnableOut}, 32'd0);
    chk("rst_wb", {27'd0, writeBackAddrOut}, 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_req", {31'd0, memReq}, 32'd0);
    chk("rst_memaddr", memAddr, 32'd0);
    chk("rst_be", {28'd0, memBe}, 32'd0);
    @(posedge clk); #1; resetIn = 1'b1;
    step();

    // Pass-through (ADD)
    validIn = 1'b1; memOpIn = 2'd0; dataIn = 32'h1234; writeEnableIn = 1'b1; writeBackAddrIn = 5'd5;
    @(negedge clk);
    chk("add_stall", {31'd0, stallOut}, 32'd0);
    step(); validIn = 1'b0;
    @(negedge clk);
    chk("add_valid", {31'd0, validOut}, 32'd1);
    chk("add_data", dataOut, 32'h1234);
    chk("add_wb", {27'd0, writeBackAddrOut}, 32'd5);
    chk("add_we", {31'd0, writeEnableOut}, 32'd1);
    chk("add_req", {31'd0, memReq}, 32'd0);
    step();
    @(negedge clk);
    chk("add_valid_drop", {31'd0, validOut}, 32'd0);
    step();

    // LB at 0x103, ack 2 cycles after request
    run_mem(2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 2);
    chk("lb_addr", c_addr, 32'h100);
    chk("lb_be", {28'd0, c_be}, 32'h8);
    chk("lb_memwe", {31'd0, c_we}, 32'd0);
    chk("lb_data", c_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_n, 32'd4);
    chk("lb_latency", lat, 32'd4);
    chk("lb_req_cycles", req_n, 32'd3);
    chk("lb_stable", {31'd0, unstable}, 32'd0);
    chk("lb_weo", {31'd0, c_weo}, 32'd1);
    chk("lb_wb", {27'd0, c_wb}, 32'd7);
    @(negedge clk);
    chk("lb_req_drop", {31'd0, memReq}, 32'd0);
    step();

    // LBU, same access
    run_mem(2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_FF7F, 2);
    chk("lbu_data", c_data, 32'h0000_0080);

    // LH signed at 0x2 (upper half)
    run_mem(2'd1, 2'd1, 1'b0, 32'h2, 32'h0, 32'h8001_1234, 1);
    chk("lh_be", {28'd0, c_be}, 32'hC);
    chk("lh_data", c_data, 32'hFFFF_8001);

    // SH at 0x202, immediate ack
    run_mem(2'd2, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    chk("sh_memwe", {31'd0, c_we}, 32'd1);
    chk("sh_be", {28'd0, c_be}, 32'hC);
    chk("sh_wdata", c_wdata, 32'hABCD_ABCD);
    chk("sh_addr", c_addr, 32'h200);
    chk("sh_weo", {31'd0, c_weo}, 32'd0);
    chk("sh_dataout", c_data, 32'h202);
    chk("sh_latency", lat, 32'd2);

    // SB at 0x1: byte replicated on all lanes
    run_mem(2'd2, 2'd0, 1'b0, 32'h1, 32'h1234_5678, 32'h0, 0);
    chk("sb_be", {28'd0, c_be}, 32'h2);
    chk("sb_wdata", c_wdata, 32'h7878_7878);

    // LW at 0x40 with no ack: timeout after 15 request cycles
    run_mem(2'd1, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, -1);
    chk("to_req_cycles", req_n, 32'd15);
    chk("to_latency", lat, 32'd16);
    chk("to_buserr", berr_n, 32'd1);
    chk("to_weo", {31'd0, c_weo}, 32'd0);
    @(negedge clk);
    chk("to_buserr_pulse", {31'd0, busErrOut}, 32'd0);
    chk("to_req_low", {31'd0, memReq}, 32'd0);
    step();

    // LW at 0x42 (misaligned)
    run_mem(2'd1, 2'd2, 1'b0, 32'h42, 32'h0, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_no_req", req_n, 32'd0);
    chk("mis_buserr", berr_n, 32'd1);
    chk("mis_weo", {31'd0, c_weo}, 32'd0);
    chk("mis_stall", stall_n, 32'd1);
`else
    chk("mis_addr", c_addr, 32'h40);
    chk("mis_be", {28'd0, c_be}, 32'hF);
    chk("mis_data", c_data, 32'h1122_3344);
    chk("mis_buserr", berr_n, 32'd0);
`endif

    // Reset in the middle of an access
    validIn = 1'b1; memOpIn = 2'd1; memSizeIn = 2'd2; dataIn = 32'h80;
    step(); validIn = 1'b0;
    step();
    @(negedge clk);
    chk("rmid_req_before", {31'd0, memReq}, 32'd1);
    @(posedge clk); #1; resetIn = 1'b0; #1;
    chk("rmid_req", {31'd0, memReq}, 32'd0);
    chk("rmid_stall", {31'd0, stallOut}, 32'd0);
    chk("rmid_memaddr", memAddr, 32'd0);
    chk("rmid_valid", {31'd0, validOut}, 32'd0);
    step(); step();
    resetIn = 1'b1;
    memAck = 1'b1;
    step(); memAck = 1'b0;
    @(negedge clk);
    chk("rmid_no_completion", {31'd0, validOut}, 32'd0);
    chk("rmid_ack_ignored", {31'd0, memReq}, 32'd0);
    step();
    validIn = 1'b1; memOpIn = 2'd3; dataIn = 32'h55; writeEnableIn = 1'b1; writeBackAddrIn = 5'd3;
    @(negedge clk);
    chk("op3_stall", {31'd0, stallOut}, 32'd0);
    step(); validIn = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'd0, validOut}, 32'd1);
    chk("post_data", dataOut, 32'h55);
    chk("post_wb", {27'd0, writeBackAddrOut}, 32'd3);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
